// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl
// ---------------------------------------------------------------------------
// Soft-start / soft-reverse controller placed directly in front of the PWM
// motor driver. Speed commands (direction + duty) arrive over a valid/ready
// handshake. The output duty slews toward the commanded duty by Step once per
// ramp tick. A direction change first brakes the duty to zero, holds zero for
// DeadTicks ticks, flips fb, and only then ramps back up. fb never toggles
// while the duty is nonzero.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-low reset
//   cmd_valid    command present
//   cmd_dir      commanded direction (1 = forward, 0 = backward)
//   cmd_duty     commanded target duty
//   cmd_ready    command accepted when cmd_valid && cmd_ready at a rising edge
//   DutyCycleOut current ramped duty, feeds the PWM DutyCycleIn
//   fb           current direction, feeds the PWM fb input
//   at_target    ramp complete (RUN, duty and direction match the target)
//   braking      high while braking to zero or holding the dead time
// ---------------------------------------------------------------------------
module motor_ramp_ctrl #(
    parameter int DC_Precision = 8,
    parameter int RampTicks    = 262144,
    parameter int Step         = 4,
    parameter int DeadTicks    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    input  logic                    cmd_dir,
    input  logic [DC_Precision-1:0] cmd_duty,
    output logic                    cmd_ready,
    output logic [DC_Precision-1:0] DutyCycleOut,
    output logic                    fb,
    output logic                    at_target,
    output logic                    braking
);

    localparam int TW = $clog2(RampTicks);
    localparam int DW = (DeadTicks > 1) ? $clog2(DeadTicks) : 1;

    localparam logic [TW-1:0]         TICK_LAST = TW'(RampTicks - 1);
    localparam logic [DW-1:0]         DEAD_LAST = DW'(DeadTicks - 1);
    localparam logic [DC_Precision:0] STEP_X    = (DC_Precision + 1)'(Step);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        BRAKE = 2'd1,
        DEAD  = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [DC_Precision-1:0] duty, duty_next;
    logic                    fb_reg, fb_next;
    logic [DW-1:0]           dead_cnt, dead_next;
    logic [TW-1:0]           tick_cnt;
    logic                    tick;
    logic [DC_Precision-1:0] target_duty;
    logic                    target_dir;
    logic                    accept;
    logic [DC_Precision-1:0] brake_duty;

    // Move cur one Step toward tgt without passing it. One guard bit keeps
    // cur+Step from wrapping near full scale.
    function automatic logic [DC_Precision-1:0] ramp_step(
        input logic [DC_Precision-1:0] cur,
        input logic [DC_Precision-1:0] tgt
    );
        logic [DC_Precision:0] cur_x;
        logic [DC_Precision:0] tgt_x;
        logic [DC_Precision:0] res_x;
        cur_x = {1'b0, cur};
        tgt_x = {1'b0, tgt};
        res_x = cur_x;
        if (cur_x < tgt_x) begin
            res_x = cur_x + STEP_X;
            if (res_x > tgt_x) res_x = tgt_x;
        end else if (cur_x > tgt_x) begin
            if ((cur_x - tgt_x) > STEP_X) res_x = cur_x - STEP_X;
            else                          res_x = tgt_x;
        end
        return DC_Precision'(res_x);
    endfunction

    // Step toward zero, clamping at zero.
    function automatic logic [DC_Precision-1:0] brake_step(
        input logic [DC_Precision-1:0] cur
    );
        logic [DC_Precision:0] cur_x;
        logic [DC_Precision:0] res_x;
        cur_x = {1'b0, cur};
        res_x = '0;
        if (cur_x > STEP_X) res_x = cur_x - STEP_X;
        return DC_Precision'(res_x);
    endfunction

    assign tick       = (tick_cnt == TICK_LAST);
    assign cmd_ready  = (state != DEAD);
    assign accept     = cmd_valid && cmd_ready;
    assign brake_duty = brake_step(duty);

    // Next-state logic: the state machine only moves on tick edges.
    always_comb begin
        state_next = state;
        duty_next  = duty;
        fb_next    = fb_reg;
        dead_next  = dead_cnt;
        if (tick) begin
            case (state)
                RUN: begin
                    if (target_dir == fb_reg) begin
                        duty_next = ramp_step(duty, target_duty);
                    end else if (duty == '0) begin
                        state_next = DEAD;
                        dead_next  = '0;
                    end else begin
                        // Enter BRAKE and take its first step on this edge.
                        duty_next = brake_duty;
                        if (brake_duty == '0) begin
                            state_next = DEAD;
                            dead_next  = '0;
                        end else begin
                            state_next = BRAKE;
                        end
                    end
                end
                BRAKE: begin
                    if (target_dir == fb_reg) begin
                        // Reversal cancelled: resume ramping in the old direction.
                        state_next = RUN;
                        duty_next  = ramp_step(duty, target_duty);
                    end else begin
                        duty_next = brake_duty;
                        if (brake_duty == '0) begin
                            state_next = DEAD;
                            dead_next  = '0;
                        end
                    end
                end
                DEAD: begin
                    duty_next = '0;
                    if (dead_cnt == DEAD_LAST) begin
                        fb_next    = target_dir;
                        state_next = RUN;
                    end else begin
                        dead_next = dead_cnt + DW'(1);
                    end
                end
                default: begin
                    state_next = RUN;
                    duty_next  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RUN;
            duty        <= '0;
            fb_reg      <= 1'b1;
            dead_cnt    <= '0;
            tick_cnt    <= '0;
            target_duty <= '0;
            target_dir  <= 1'b1;
        end else begin
            state    <= state_next;
            duty     <= duty_next;
            fb_reg   <= fb_next;
            dead_cnt <= dead_next;
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            // The step on a tick edge sees the previously registered target.
            if (accept) begin
                target_duty <= cmd_duty;
                target_dir  <= cmd_dir;
            end
        end
    end

    assign DutyCycleOut = duty;
    assign fb           = fb_reg;
    assign at_target    = (state == RUN) && (duty == target_duty) && (fb_reg == target_dir);
    assign braking      = (state == BRAKE) || (state == DEAD);

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with RampTicks=4, Step=16, DeadTicks=2.
module tb_motor_ramp_ctrl;

    localparam int DCP = 8;
    localparam int RT  = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           cmd_valid;
    logic           cmd_dir;
    logic [DCP-1:0] cmd_duty;
    logic           cmd_ready;
    logic [DCP-1:0] DutyCycleOut;
    logic           fb;
    logic           at_target;
    logic           braking;

    int n_tests = 0;
    int n_fail  = 0;
    int since_tick = 0;
    bit mon_en = 1'b0;
    logic           prev_fb;
    logic [DCP-1:0] prev_duty;

    motor_ramp_ctrl #(
        .DC_Precision(DCP),
        .RampTicks   (RT),
        .Step        (16),
        .DeadTicks   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_dir     (cmd_dir),
        .cmd_duty    (cmd_duty),
        .cmd_ready   (cmd_ready),
        .DutyCycleOut(DutyCycleOut),
        .fb          (fb),
        .at_target   (at_target),
        .braking     (braking)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle 1 time unit past it.
    task automatic clk1();
        @(posedge clk);
        #1;
        since_tick = (since_tick + 1) % RT;
    endtask

    // Advance to just after the next ramp-tick edge.
    task automatic next_tick();
        do clk1(); while (since_tick != 0);
    endtask

    task automatic send_cmd(input logic dir, input logic [DCP-1:0] duty);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_duty  = duty;
        clk1();
        cmd_valid = 1'b0;
    endtask

    // Apply reset for one edge with a command offered; it must not be captured.
    task automatic reset_with_cmd(input string tag);
        reset     = 1'b0;
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_duty  = 8'd200;
        clk1();
        chk({tag, "_duty"},  DutyCycleOut, 0);
        chk({tag, "_fb"},    fb, 1);
        chk({tag, "_ready"}, cmd_ready, 1);
        chk({tag, "_brk"},   braking, 0);
        chk({tag, "_attgt"}, at_target, 1);
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        since_tick = 0;
        next_tick();
        chk({tag, "_duty_after_tick"}, DutyCycleOut, 0);
        chk({tag, "_attgt_after_tick"}, at_target, 1);
    endtask

    task automatic ramp_seq(input string tag, input int n, input int v0, input int v1,
                            input int v2, input int v3);
        int vals[4];
        vals = '{v0, v1, v2, v3};
        for (int i = 0; i < n; i++) begin
            next_tick();
            chk(tag, DutyCycleOut, vals[i]);
        end
    endtask

    // fb may only change while the duty is zero on both sides of the edge.
    always @(negedge clk) begin
        if (mon_en && reset && (fb !== prev_fb)) begin
            chk("fb_flip_prev_duty", prev_duty, 0);
            chk("fb_flip_duty", DutyCycleOut, 0);
        end
        prev_fb   = fb;
        prev_duty = DutyCycleOut;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b1;
        cmd_duty  = '0;

        // 1. Reset
        repeat (3) @(posedge clk);
        #1;
        reset      = 1'b1;
        since_tick = 0;
        mon_en     = 1'b1;
        chk("rst_duty",  DutyCycleOut, 0);
        chk("rst_fb",    fb, 1);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_attgt", at_target, 1);
        chk("rst_brk",   braking, 0);
        next_tick();
        chk("first_tick_duty", DutyCycleOut, 0);

        // 2. Ramp up to 64
        send_cmd(1'b1, 8'd64);
        chk("up_attgt_start", at_target, 0);
        next_tick();
        chk("up_16", DutyCycleOut, 16);
        clk1();
        chk("up_16_stable", DutyCycleOut, 16);
        chk("up_attgt_mid", at_target, 0);
        ramp_seq("up_seq", 3, 32, 48, 64, 0);
        chk("up_attgt_end", at_target, 1);
        chk("up_fb", fb, 1);

        // 3. Same-direction ramp to zero, then non-multiple targets
        send_cmd(1'b1, 8'd0);
        ramp_seq("down0_seq", 4, 48, 32, 16, 0);
        chk("down0_brk", braking, 0);
        chk("down0_attgt", at_target, 1);
        send_cmd(1'b1, 8'd40);
        ramp_seq("to40_seq", 4, 16, 32, 40, 40);
        chk("to40_attgt", at_target, 1);
        send_cmd(1'b1, 8'd10);
        ramp_seq("to10_seq", 3, 24, 10, 10, 0);

        // 4. Reversal from fwd/64 to back/32
        send_cmd(1'b1, 8'd64);
        ramp_seq("re64_seq", 4, 26, 42, 58, 64);
        send_cmd(1'b0, 8'd32);
        next_tick();
        chk("rev_48", DutyCycleOut, 48);
        chk("rev_brk_first", braking, 1);
        chk("rev_attgt_brk", at_target, 0);
        ramp_seq("rev_brake_seq", 3, 32, 16, 0, 0);
        chk("dead_ready", cmd_ready, 0);
        chk("dead_brk", braking, 1);
        next_tick();
        chk("dead1_duty", DutyCycleOut, 0);
        chk("dead1_fb", fb, 1);
        chk("dead1_ready", cmd_ready, 0);
        next_tick();
        chk("flip_fb", fb, 0);
        chk("flip_duty", DutyCycleOut, 0);
        chk("flip_ready", cmd_ready, 1);
        chk("flip_brk", braking, 0);
        ramp_seq("rev_up_seq", 2, 16, 32, 0, 0);
        chk("rev_attgt", at_target, 1);
        chk("rev_brk_end", braking, 0);

        // Back to forward 64 so the cancellation case starts forward.
        send_cmd(1'b1, 8'd64);
        ramp_seq("back_fwd_seq", 4, 16, 0, 0, 0);
        chk("back_fwd_fb", fb, 1);
        ramp_seq("back_fwd_up", 4, 16, 32, 48, 64);

        // 5. Cancelled reversal
        send_cmd(1'b0, 8'd32);
        ramp_seq("cancel_brake", 2, 48, 32, 0, 0);
        chk("cancel_brk_before", braking, 1);
        send_cmd(1'b1, 8'd64);
        next_tick();
        chk("cancel_48", DutyCycleOut, 48);
        chk("cancel_brk", braking, 0);
        next_tick();
        chk("cancel_64", DutyCycleOut, 64);
        chk("cancel_attgt", at_target, 1);
        chk("cancel_fb", fb, 1);

        // 6a. Reset during DEAD
        send_cmd(1'b0, 8'd32);
        ramp_seq("r6_brake", 4, 48, 32, 16, 0);
        chk("r6_in_dead", cmd_ready, 0);
        reset_with_cmd("rst_dead");

        // 6b. Reset mid-ramp at 48
        send_cmd(1'b1, 8'd64);
        ramp_seq("r6_up", 3, 16, 32, 48, 0);
        reset_with_cmd("rst_ramp");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
